// File: rtl/job_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : job_resp_pkg
//  Description : Shared state encoding and default widths for the job
//                responder slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package job_resp_pkg;

    localparam int c_STATE_W = 2;
    localparam int c_CNT_W   = 4;
    localparam int c_STAT_W  = 8;

    // The unused encoding 2'd3 is recovered to IDLE by the FSM.
    typedef enum logic [c_STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COOL = 2'd2
    } state_t;

`ifndef SYNTHESIS
    // Readable state name for waveform / debug viewing.
    function automatic string state_name(state_t s);
        case (s)
            IDLE:    return "IDLE";
            RUN:     return "RUN";
            COOL:    return "COOL";
            default: return "ILLEGAL";
        endcase
    endfunction
`endif

endpackage : job_resp_pkg
`default_nettype wire

// File: rtl/job_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : job_responder_if
//  Description : Enter/exit job handshake bundle between an initiator and
//                the job responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface job_responder_if
    import job_resp_pkg::*;
#(
    parameter int CNT_W  = c_CNT_W,
    parameter int STAT_W = c_STAT_W
) ();

    logic              enter;
    logic [CNT_W-1:0]  len;
    logic              abort;
    logic              clr_ovr;
    logic              busy;
    logic              exit;
    logic              aborted;
    logic [CNT_W-1:0]  cnt;
    logic [STAT_W-1:0] done_cnt;
    logic              overrun;

    modport master (
        output enter, len, abort, clr_ovr,
        input  busy, exit, aborted, cnt, done_cnt, overrun
    );

    modport slave (
        input  enter, len, abort, clr_ovr,
        output busy, exit, aborted, cnt, done_cnt, overrun
    );

endinterface : job_responder_if
`default_nettype wire

// File: rtl/job_responder_stat.sv
`default_nettype none
// ============================================================================
//  Module      : job_resp_stat
//  Description : Completed-job tally and sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module job_resp_stat
    import job_resp_pkg::*;
#(
    parameter int STAT_W = c_STAT_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_exit,
    input  wire logic              i_enter,
    input  wire logic              i_not_idle,
    input  wire logic              i_clr_ovr,
    output logic      [STAT_W-1:0] o_done_cnt,
    output logic                   o_overrun
);

    logic [STAT_W-1:0] r_done_cnt;
    logic              r_overrun;

    // Count completed jobs; wraps naturally at the counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_cnt <= '0;
        end else if (i_exit) begin
            r_done_cnt <= r_done_cnt + 1'b1;
        end
    end

    // Sticky overrun: a request while busy sets it, and a set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (i_enter && i_not_idle) begin
            r_overrun <= 1'b1;
        end else if (i_clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_done_cnt = r_done_cnt;
    assign o_overrun  = r_overrun;

endmodule : job_resp_stat
`default_nettype wire

// File: rtl/job_responder.sv
`default_nettype none
// ============================================================================
//  Module      : job_responder
//  Description : Responder end of the enter/exit job handshake. Loads a
//                terminal count, counts once per cycle and strobes exit on
//                completion; supports abort, overrun flagging and a tally.
//  Revision    : 1.0 - initial release
// ============================================================================
module job_responder
    import job_resp_pkg::*;
#(
    parameter int CNT_W  = c_CNT_W,
    parameter int STAT_W = c_STAT_W
) (
    input  wire logic       clk,
    input  wire logic       rst,
    job_responder_if.slave  bus
);

    state_t            r_state;
    state_t            w_nextstate;
    logic              w_exit;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_len_q;
    logic              r_busy;
    logic              r_aborted;
    logic [STAT_W-1:0] w_done_cnt;
    logic              w_overrun;
    logic              w_not_idle;

    // Next-state decode and the combinational completion strobe; abort wins
    // over a coincident terminal count so no exit is seen on an aborted job.
    always_comb begin
        w_nextstate = IDLE;
        w_exit      = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextstate = bus.enter ? RUN : IDLE;
            end
            RUN: begin
                if (bus.abort) begin
                    w_nextstate = IDLE;
                end else if (r_cnt >= r_len_q) begin
                    w_nextstate = COOL;
                    w_exit      = 1'b1;
                end else begin
                    w_nextstate = RUN;
                end
            end
            COOL: begin
                w_nextstate = IDLE;
            end
            default: begin
                w_nextstate = IDLE;
            end
        endcase
    end

    // State register and registered outputs, all keyed on the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_len_q   <= '0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_nextstate;
            r_busy    <= (w_nextstate == RUN) || (w_nextstate == COOL);
            r_aborted <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_nextstate == RUN) begin
                        r_len_q <= bus.len;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (w_nextstate == RUN) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // Leaving RUN straight to IDLE can only be an abort.
                        r_cnt     <= '0;
                        r_aborted <= (w_nextstate == IDLE);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign w_not_idle = (r_state != IDLE);

    job_resp_stat #(
        .STAT_W (STAT_W)
    ) u_stat (
        .clk        (clk),
        .rst        (rst),
        .i_exit     (w_exit),
        .i_enter    (bus.enter),
        .i_not_idle (w_not_idle),
        .i_clr_ovr  (bus.clr_ovr),
        .o_done_cnt (w_done_cnt),
        .o_overrun  (w_overrun)
    );

    assign bus.busy     = r_busy;
    assign bus.exit     = w_exit;
    assign bus.aborted  = r_aborted;
    assign bus.cnt      = r_cnt;
    assign bus.done_cnt = w_done_cnt;
    assign bus.overrun  = w_overrun;

`ifndef SYNTHESIS
    // Debug-only state name for waveform viewing.
    string w_state_name_unused;
    always_comb begin
        w_state_name_unused = state_name(r_state);
    end
`endif

endmodule : job_responder
`default_nettype wire
